best_1ofn_busy_pipe: RTL and testbench

Parametrised successor to the fixed 32-key best-1-of-32 busy sorter. Finds the best pattern among NKEY key 1/2-strips using a compare-by-twos tree, with busy masking, a carried payload and lower-key tie preference. Pipeline register placement is selectable per tree stage. Adds a valid pipeline, a clock-enable stall and asynchronous reset. Sits between the per-key pattern finders and the CLCT best/second-best selection.

---
 rtl/best_1ofn_busy_pipe.sv | 155 +++++++++++++++
 tb/tb_best_1ofn_busy_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/best_1ofn_busy_pipe.sv
// Best-1-of-NKEY pattern sorter: a compare-by-twos tree with busy masking,
// a carried payload, lower-key tie preference and per-stage pipeline registers.
//
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-high, clears all pipeline registers
//   ce         : clock enable, 0 freezes every pipeline register
//   in_vld     : input set valid
//   bsy        : per-key busy flags
//   pat        : flat pattern bus, key k at [k*PATB +: PATB]
//   carry      : flat payload bus, key k at [k*CARB +: CARB]
//   best_pat   : winning pattern
//   best_key   : winning key index
//   best_carry : winner payload
//   best_bsy   : winner busy (only when every key is busy)
//   best_vld   : in_vld delayed by popcount(PIPE_MASK) enabled cycles
module best_1ofn_busy_pipe #(
  parameter int NKEY     = 32,
  parameter int NKEYB    = 5,
  parameter int PATB     = 7,
  parameter int SORT_LSB = 1,
  parameter int CARB     = 11,
  parameter     PIPE_MASK = 5'b01000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   in_vld,
  input  logic [NKEY-1:0]        bsy,
  input  logic [NKEY*PATB-1:0]   pat,
  input  logic [NKEY*CARB-1:0]   carry,
  output logic [PATB-1:0]        best_pat,
  output logic [NKEYB-1:0]       best_key,
  output logic [CARB-1:0]        best_carry,
  output logic                   best_bsy,
  output logic                   best_vld
);

  if (NKEY != (1 << NKEYB)) begin : g_err_nkey
    $error("NKEY must equal 2**NKEYB");
  end
  if (SORT_LSB >= PATB) begin : g_err_sort
    $error("SORT_LSB must be below PATB");
  end
  if ($bits(PIPE_MASK) != NKEYB) begin : g_err_mask
    $error("PIPE_MASK width must equal NKEYB");
  end

  // Level l holds NKEY>>l candidates; level 0 are the leaves,
  // level l (l>=1) is the result of tree stage l-1.
  for (genvar l = 0; l <= NKEYB; l++) begin : g_lv
    localparam int NC = NKEY >> l;

    logic [PATB-1:0]  w_pat [NC];
    logic [NKEYB-1:0] w_key [NC];
    logic [CARB-1:0]  w_car [NC];
    logic             w_bsy [NC];
    logic             w_vld;

    if (l == 0) begin : g_in
      for (genvar k = 0; k < NC; k++) begin : g_k
        assign w_pat[k] = pat[k*PATB +: PATB];
        assign w_car[k] = carry[k*CARB +: CARB];
        assign w_bsy[k] = bsy[k];
        assign w_key[k] = '0;
      end
      assign w_vld = in_vld;
    end else begin : g_st
      localparam int S = l - 1;
      localparam logic [NKEYB-1:0] KBIT = NKEYB'(1) << S;

      logic [PATB-1:0]  w_spat [NC];
      logic [NKEYB-1:0] w_skey [NC];
      logic [CARB-1:0]  w_scar [NC];
      logic             w_sbsy [NC];

      for (genvar j = 0; j < NC; j++) begin : g_pr
        logic [PATB-1:0] w_hp;
        logic [PATB-1:0] w_lp;
        logic            w_hb;
        logic            w_lb;
        logic            w_sel;

        assign w_hp = g_lv[l-1].w_pat[2*j+1];
        assign w_lp = g_lv[l-1].w_pat[2*j];
        assign w_hb = g_lv[l-1].w_bsy[2*j+1];
        assign w_lb = g_lv[l-1].w_bsy[2*j];

        // Strict greater-than keeps the even (lower) key on ties.
        assign w_sel = ((w_hp[PATB-1:SORT_LSB] >
                         w_lp[PATB-1:SORT_LSB]) | w_lb)
                       & ~w_hb;

        assign w_spat[j] = w_sel ? w_hp : w_lp;
        assign w_sbsy[j] = w_sel ? w_hb : w_lb;
        assign w_scar[j] = w_sel ? g_lv[l-1].w_car[2*j+1]
                                 : g_lv[l-1].w_car[2*j];
        // Select bit becomes key bit S; lower bits come from the winner.
        assign w_skey[j] = w_sel ? (g_lv[l-1].w_key[2*j+1] | KBIT)
                                 : g_lv[l-1].w_key[2*j];
      end

      if (PIPE_MASK[S]) begin : g_reg
        logic [PATB-1:0]  r_pat [NC];
        logic [NKEYB-1:0] r_key [NC];
        logic [CARB-1:0]  r_car [NC];
        logic             r_bsy [NC];
        logic             r_vld;

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            r_vld <= 1'b0;
            for (int j = 0; j < NC; j++) begin
              r_pat[j] <= '0;
              r_key[j] <= '0;
              r_car[j] <= '0;
              r_bsy[j] <= 1'b0;
            end
          end else if (ce) begin
            r_vld <= g_lv[l-1].w_vld;
            for (int j = 0; j < NC; j++) begin
              r_pat[j] <= w_spat[j];
              r_key[j] <= w_skey[j];
              r_car[j] <= w_scar[j];
              r_bsy[j] <= w_sbsy[j];
            end
          end
        end

        for (genvar j = 0; j < NC; j++) begin : g_o
          assign w_pat[j] = r_pat[j];
          assign w_key[j] = r_key[j];
          assign w_car[j] = r_car[j];
          assign w_bsy[j] = r_bsy[j];
        end
        assign w_vld = r_vld;
      end else begin : g_cmb
        for (genvar j = 0; j < NC; j++) begin : g_o
          assign w_pat[j] = w_spat[j];
          assign w_key[j] = w_skey[j];
          assign w_car[j] = w_scar[j];
          assign w_bsy[j] = w_sbsy[j];
        end
        assign w_vld = g_lv[l-1].w_vld;
      end
    end
  end

  assign best_pat   = g_lv[NKEYB].w_pat[0];
  assign best_key   = g_lv[NKEYB].w_key[0];
  assign best_carry = g_lv[NKEYB].w_car[0];
  assign best_bsy   = g_lv[NKEYB].w_bsy[0];
  assign best_vld   = g_lv[NKEYB].w_vld;

endmodule

// File: tb/tb_best_1ofn_busy_pipe.sv
// Scoreboard bench for best_1ofn_busy_pipe: a 32-key default instance
// and a 64-key instance with two pipeline stages share the same stimulus.
module tb_best_1ofn_busy_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ce;
  logic         in_vld;
  logic [63:0]  bsy_v;
  logic [6:0]   pv [64];
  logic [10:0]  cv [64];
  logic [447:0] pat_f;
  logic [703:0] car_f;

  logic [6:0]  a_pat, b_pat;
  logic [4:0]  a_key;
  logic [5:0]  b_key;
  logic [10:0] a_car, b_car;
  logic        a_bsy, b_bsy, a_vld, b_vld;

  best_1ofn_busy_pipe u_a (
    .clock(clk), .reset(rst), .ce(ce), .in_vld(in_vld),
    .bsy(bsy_v[31:0]), .pat(pat_f[223:0]), .carry(car_f[351:0]),
    .best_pat(a_pat), .best_key(a_key), .best_carry(a_car),
    .best_bsy(a_bsy), .best_vld(a_vld)
  );

  best_1ofn_busy_pipe #(
    .NKEY(64), .NKEYB(6), .PIPE_MASK(6'b100100)
  ) u_b (
    .clock(clk), .reset(rst), .ce(ce), .in_vld(in_vld),
    .bsy(bsy_v), .pat(pat_f), .carry(car_f),
    .best_pat(b_pat), .best_key(b_key), .best_carry(b_car),
    .best_bsy(b_bsy), .best_vld(b_vld)
  );

  typedef struct {
    logic [6:0]  pat;
    logic [5:0]  key;
    logic [10:0] car;
    logic        bsy;
    int          ec;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t la, lb, ea, eb;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;
  logic ce_q = 1'b0;

  always @(posedge clk) begin
    ce_q <= ce;
    if (ce) ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  // Reference: highest rank wins, first (lowest) key wins ties.
  // Busy keys rank below every non-busy key; all-busy gives key 0.
  function automatic exp_t model(input int n);
    exp_t e;
    int   br;
    int   r;
    br = -1;
    e.key = '0;
    for (int k = 0; k < n; k++) begin
      r = bsy_v[k] ? 0 : (64 | int'(pv[k][6:1]));
      if (r > br) begin
        br = r;
        e.key = 6'(k);
      end
    end
    e.pat = pv[e.key];
    e.car = cv[e.key];
    e.bsy = bsy_v[e.key];
    e.ec  = ecnt;
    return e;
  endfunction

  task automatic chk_a(input exp_t e, input string t);
    chk({t, "a_pat"}, 32'(a_pat), 32'(e.pat));
    chk({t, "a_key"}, 32'(a_key), 32'(e.key));
    chk({t, "a_car"}, 32'(a_car), 32'(e.car));
    chk({t, "a_bsy"}, 32'(a_bsy), 32'(e.bsy));
  endtask

  task automatic chk_b(input exp_t e, input string t);
    chk({t, "b_pat"}, 32'(b_pat), 32'(e.pat));
    chk({t, "b_key"}, 32'(b_key), 32'(e.key));
    chk({t, "b_car"}, 32'(b_car), 32'(e.car));
    chk({t, "b_bsy"}, 32'(b_bsy), 32'(e.bsy));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_vld) begin
        if (!ce_q) chk_a(la, "hold_");
        else if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_unexpected: got best_vld=1, want no output");
        end else begin
          ea = qa.pop_front();
          chk_a(ea, "");
          chk("a_lat", 32'(ecnt - ea.ec), 32'd1);
          la = ea;
        end
      end
      if (b_vld) begin
        if (!ce_q) chk_b(lb, "hold_");
        else if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected: got best_vld=1, want no output");
        end else begin
          eb = qb.pop_front();
          chk_b(eb, "");
          chk("b_lat", 32'(ecnt - eb.ec), 32'd2);
          lb = eb;
        end
      end
    end
  end

  task automatic clear();
    bsy_v = '0;
    for (int k = 0; k < 64; k++) begin
      pv[k] = '0;
      cv[k] = 11'(k * 37 + 5);
    end
  endtask

  task automatic apply(input bit v, input bit c);
    in_vld = v;
    ce = c;
    for (int k = 0; k < 64; k++) begin
      pat_f[k*7 +: 7]   = pv[k];
      car_f[k*11 +: 11] = cv[k];
    end
    if (v && c) begin
      qa.push_back(model(32));
      qb.push_back(model(64));
    end
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "a_vld"}, 32'(a_vld), 0);
    chk({t, "a_pat"}, 32'(a_pat), 0);
    chk({t, "a_key"}, 32'(a_key), 0);
    chk({t, "a_car"}, 32'(a_car), 0);
    chk({t, "a_bsy"}, 32'(a_bsy), 0);
    chk({t, "b_vld"}, 32'(b_vld), 0);
    chk({t, "b_pat"}, 32'(b_pat), 0);
    chk({t, "b_key"}, 32'(b_key), 0);
    chk({t, "b_car"}, 32'(b_car), 0);
    chk({t, "b_bsy"}, 32'(b_bsy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    ce = 1'b0;
    in_vld = 1'b0;
    clear();
    pat_f = '0;
    car_f = '0;
    #1 rst = 1'b1;
    #1 chk_zero("rst_");
    @(negedge clk);
    #1 rst = 1'b0;

    // single winner with payload
    clear(); pv[17] = 7'h50; cv[17] = 11'h2AB; apply(1, 1);
    // tie on sort field, lsb ignored
    clear(); pv[4] = 7'h40; pv[9] = 7'h40; pv[20] = 7'h41; apply(1, 1);
    // busy masking
    clear(); pv[31] = 7'h7E; bsy_v[31] = 1'b1; pv[2] = 7'h10; apply(1, 1);
    // all busy
    clear(); bsy_v = '1; pv[0] = 7'h03; pv[5] = 7'h70; apply(1, 1);
    // upper half winner only visible to the 64-key instance
    clear(); pv[63] = 7'h7F; pv[40] = 7'h7E; pv[10] = 7'h20; apply(1, 1);
    apply(0, 1);
    apply(0, 1);

    // stall between two sets
    clear(); pv[7] = 7'h33; apply(1, 1);
    repeat (3) apply(0, 0);
    clear(); pv[12] = 7'h55; apply(1, 1);
    apply(0, 1);
    apply(0, 1);

    // async reset mid-stream
    clear(); pv[3] = 7'h22; apply(1, 1);
    clear(); pv[5] = 7'h66; apply(1, 1);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #2 chk_zero("midrst_");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    clear(); pv[9] = 7'h11; apply(1, 1);
    apply(0, 1);
    apply(0, 1);

    // random sweep with random stalls
    repeat (200) begin
      for (int k = 0; k < 64; k++) begin
        pv[k] = 7'($urandom_range(0, 15));
        cv[k] = 11'($urandom);
        bsy_v[k] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 9) == 0) bsy_v = '1;
      if ($urandom_range(0, 3) == 0) pv[$urandom_range(0, 63)] = 7'($urandom);
      apply($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
    end

    repeat (4) apply(0, 1);
    chk("a_drain", 32'(qa.size()), 0);
    chk("b_drain", 32'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
